// File: rtl/golden_nonce_arbiter_if.sv
// Handshake between the nonce arbiter (master) and serial_transmit (slave).
// The master raises tx_send with tx_word. It holds both until it sees tx_busy.
interface golden_nonce_arbiter_if;
    logic        tx_send;
    logic [31:0] tx_word;
    logic        tx_busy;

    modport master (output tx_send, output tx_word, input tx_busy);
    modport slave  (input tx_send, input tx_word, output tx_busy);
endinterface

// File: rtl/golden_nonce_arbiter.sv
// Golden-nonce arbiter.
// Each core has one pending slot. A round-robin arbiter moves pending nonces
// into a small FIFO, and a TX FSM feeds the FIFO head to serial_transmit.
// Any report that overwrites an unsent pending nonce is counted as a drop.
// The drop counter saturates.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | nothing in flight; pop the head when the FIFO has data and tx is idle
// S_REQ   | tx_send high with tx_word held; waiting for tx_busy
// S_DRAIN | transmitter accepted the word; waiting for tx_busy to fall
module golden_nonce_arbiter #(
    parameter int NUM_CORES  = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int DROP_W     = 8
) (
    input  logic                          i_hash_clk,
    input  logic                          i_reset_n,
    input  logic                          i_flush,
    input  logic [NUM_CORES-1:0]          i_core_valid,
    input  logic [32*NUM_CORES-1:0]       i_core_nonce,
    golden_nonce_arbiter_if.master        tx_if,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic [DROP_W-1:0]             o_drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

    state_t                r_state, w_state_nxt;
    logic [NUM_CORES-1:0]  r_pending;
    logic [31:0]           r_pend_nonce [NUM_CORES];
    logic [GW-1:0]         r_last_grant;
    logic [31:0]           r_fifo [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [AW:0]           r_count;
    logic [DROP_W-1:0]     r_drop;
    logic [31:0]           r_tx_word;

    logic                  w_fifo_full, w_fifo_empty, w_push, w_pop;
    logic                  w_grant_vld;
    logic [NUM_CORES-1:0]  w_grant;
    logic [GW-1:0]         w_grant_core;
    logic [31:0]           w_grant_nonce;
    int                    w_idx;
    logic [4:0]            w_drop_num;
    logic [DROP_W+4:0]     w_drop_sum;
    logic [DROP_W-1:0]     w_drop_nxt;

    assign w_fifo_full  = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_fifo_empty = (r_count == '0);
    assign w_push       = w_grant_vld;
    // A flush empties the queue, so it also suppresses the pop in that cycle.
    assign w_pop        = (r_state == S_IDLE) && !w_fifo_empty && !tx_if.tx_busy && !i_flush;

    assign tx_if.tx_send = (r_state == S_REQ);
    assign tx_if.tx_word = r_tx_word;
    assign o_fifo_count  = r_count;
    assign o_drop_count  = r_drop;

    // Round-robin grant: the search starts at the core after the last grant and wraps around.
    always_comb begin
        w_grant_vld   = 1'b0;
        w_grant       = '0;
        w_grant_core  = '0;
        w_grant_nonce = '0;
        w_idx         = 0;
        if (!i_flush && !w_fifo_full) begin
            for (int k = 1; k <= NUM_CORES; k++) begin
                w_idx = int'(r_last_grant) + k;
                if (w_idx >= NUM_CORES) w_idx = w_idx - NUM_CORES;
                if (!w_grant_vld && r_pending[w_idx]) begin
                    w_grant_vld    = 1'b1;
                    w_grant[w_idx] = 1'b1;
                    w_grant_core   = GW'(w_idx);
                    w_grant_nonce  = r_pend_nonce[w_idx];
                end
            end
        end
    end

    // Count the reports that overwrite an ungranted pending nonce, then add them to the counter with saturation.
    always_comb begin
        w_drop_num = '0;
        w_drop_nxt = r_drop;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!i_flush && i_core_valid[i] && r_pending[i] && !w_grant[i])
                w_drop_num = w_drop_num + 5'd1;
        end
        w_drop_sum = {5'b0, r_drop} + {{DROP_W{1'b0}}, w_drop_num};
        if (w_drop_sum > {5'b0, {DROP_W{1'b1}}})
            w_drop_nxt = '1;
        else
            w_drop_nxt = w_drop_sum[DROP_W-1:0];
    end

    // Capture stage: a new report always wins over a grant in the same cycle.
    always_ff @(posedge i_hash_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pending    <= '0;
            r_last_grant <= '0;
            r_drop       <= '0;
            for (int i = 0; i < NUM_CORES; i++) r_pend_nonce[i] <= '0;
        end else begin
            r_drop <= w_drop_nxt;
            if (w_grant_vld) r_last_grant <= w_grant_core;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (i_flush) begin
                    r_pending[i] <= 1'b0;
                end else if (i_core_valid[i]) begin
                    r_pending[i]    <= 1'b1;
                    r_pend_nonce[i] <= i_core_nonce[32*i +: 32];
                end else if (w_grant[i]) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    // FIFO storage has no reset; the pointers and count define which entries are valid.
    always_ff @(posedge i_hash_clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_grant_nonce;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge i_hash_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Output word register, loaded when the head is popped.
    always_ff @(posedge i_hash_clk or negedge i_reset_n) begin
        if (!i_reset_n)  r_tx_word <= '0;
        else if (w_pop)  r_tx_word <= r_fifo[r_rd_ptr];
    end

    // TX FSM state register.
    always_ff @(posedge i_hash_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    // TX FSM next state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_pop)          w_state_nxt = S_REQ;
            S_REQ:   if (tx_if.tx_busy)  w_state_nxt = S_DRAIN;
            S_DRAIN: if (!tx_if.tx_busy) w_state_nxt = S_IDLE;
            default:                     w_state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: doc/golden_nonce_arbiter.md
Name: golden_nonce_arbiter

Overview:
- Collects golden-nonce reports from NUM_CORES hashing cores and queues them in a small FIFO.
- Feeds the queue one word at a time into the serial transmitter through its send/busy handshake.
- Sits between the hash-core array and serial_transmit; replaces a single-core direct connection to the transmitter's send/word inputs.
- Also keeps a saturating count of reports lost to overrun.

Parameters:
- NUM_CORES, 4, number of reporting cores (1..16).
- FIFO_DEPTH, 8, queue entries; power of 2, at least 2.
- DROP_W, 8, width of the drop counter.

Ports:
- hash_clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  sync pulse on new work load; clears the queue and pending reports.
- core_valid  in  NUM_CORES  one-cycle pulse per core: golden nonce found.
- core_nonce  in  32*NUM_CORES  core i nonce on bits [32*i+31:32*i]; valid with core_valid[i].
- tx_busy  in  1  busy from serial_transmit.
- tx_send  out  1  send request to serial_transmit.
- tx_word  out  32  word to serial_transmit; stable while tx_send is high and while tx_busy is high.
- fifo_count  out  log2(FIFO_DEPTH)+1  current queue occupancy.
- drop_count  out  DROP_W  saturating count of lost reports.

Behaviour:
- Reset (asynchronous, active-low; release is synchronous to hash_clk): tx_send=0, tx_word=0, fifo_count=0, drop_count=0, all pending flags 0, round-robin pointer 0, TX FSM in IDLE.
- Capture stage (one pending register per core):
  - When core_valid[i] is seen, core_nonce[i] is latched and pending[i] is set.
  - If pending[i] is already set and not granted that cycle, the old value is overwritten by the newest report and drop_count increments.
- Arbiter:
  - Each cycle, if any pending flag is set and the FIFO is not full, it grants one core round-robin, searching from last_grant+1 upward with wrap-around.
  - The granted nonce is written to the FIFO and pending[i] is cleared.
  - If core_valid[i] arrives in the same cycle as grant[i], the new nonce is latched and pending[i] stays set; this is not a drop.
- Latency: core_valid at edge t, FIFO write at edge t+1, pop at edge t+2 (FIFO previously empty, FSM IDLE). tx_send is therefore high in the cycle after edge t+2.
- FIFO:
  - Write and pop in the same cycle are allowed; fifo_count is unchanged.
  - While full, the arbiter stalls and pending flags hold.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- TX FSM:
  - IDLE: if fifo_count>0 and tx_busy=0, pop the head into tx_word, set tx_send=1, go to REQ.
  - REQ: hold tx_send=1 and tx_word until tx_busy is sampled 1, then clear tx_send and go to DRAIN.
  - DRAIN: wait until tx_busy is sampled 0, then go to IDLE.
  - Minimum two cycles between successive tx_send assertions.
- drop_count saturates at all-ones and does not wrap. It is not cleared by flush.
- flush:
  - Synchronously clears the FIFO (count=0) and all pending flags.
  - core_valid in the same cycle is discarded and not counted as a drop.
  - Does not abort a word already popped: REQ/DRAIN complete normally.
- Reset asserted mid-transfer: tx_send drops immediately (asynchronously); the word is lost and not counted.

Test Plan:
- Single report: core 2 pulses core_valid with nonce 0x1A2B3C4D, tx_busy modelled as going high 1 cycle after tx_send for 20 cycles -> tx_send rises 3 cycles after the pulse, tx_word=0x1A2B3C4D, exactly one send, fifo_count returns to 0.
- Simultaneous reports: cores 0..3 pulse in the same cycle with nonces 0x10..0x13, pointer at reset value -> FIFO order 0x11,0x12,0x13,0x10 (search starts at core 1); four sends in that order with no drops.
- Overflow: tx_busy held at 1, core 0 pulses 10 times with nonces 1..10 on separate cycles (FIFO_DEPTH=8) -> 8 words queued, one pending, drop_count=1 with nonce 10 retained. After release, words 1..8 then 10 are sent.
- Saturation: 300 lost reports with DROP_W=8 -> drop_count=255 and stays there.
- Flush during transfer: 3 words queued, flush pulsed while in DRAIN -> the in-flight word completes, no further tx_send, fifo_count=0.
- Async reset in REQ: reset_n pulled low between clock edges -> tx_send=0 before the next edge, all counters 0; the FSM resumes cleanly on new reports.
